// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: a phase accumulator emits oversample ticks at
// baud_rate*OVS per clk_freq cycles on average, plus bit-boundary and mid-bit ticks.
module baud_gen_frac #(
  parameter int CLK_W  = 32,
  parameter int BAUD_W = 24,
  parameter int OVS    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CLK_W-1:0]  clk_freq,
  input  logic [BAUD_W-1:0] baud_rate,
  input  logic              enable,
  input  logic              resync,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              mid_tick,
  output logic              cfg_err
);
  localparam int OVS_LG = $clog2(OVS);
  localparam int INC_W  = (BAUD_W + OVS_LG > CLK_W + 1) ? BAUD_W + OVS_LG : CLK_W + 1;

  logic [CLK_W-1:0]  shadow_clk, acc, acc_nxt;
  logic [BAUD_W-1:0] shadow_baud;
  logic [OVS_LG-1:0] os_cnt;
  logic [INC_W-1:0]  inc, inc_in;
  logic [CLK_W:0]    sum, sum_sub;
  logic              wrap, cfg_bad_in;

  assign inc    = INC_W'(shadow_baud) << OVS_LG;
  assign inc_in = INC_W'(baud_rate) << OVS_LG;

  // Evaluated on the values being shadowed so cfg_err always describes the live shadow.
  assign cfg_bad_in = (baud_rate == '0) || (clk_freq == '0) || (inc_in > INC_W'(clk_freq));

  // inc <= shadow_clk whenever accumulation runs, so the low CLK_W+1 bits hold it exactly.
  assign sum     = {1'b0, acc} + inc[CLK_W:0];
  assign wrap    = sum >= {1'b0, shadow_clk};
  assign sum_sub = sum - {1'b0, shadow_clk};
  assign acc_nxt = wrap ? sum_sub[CLK_W-1:0] : sum[CLK_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_clk  <= '0;
      shadow_baud <= '0;
      cfg_err     <= 1'b1;
      acc         <= '0;
      os_cnt      <= '0;
      os_tick     <= 1'b0;
      bit_tick    <= 1'b0;
      mid_tick    <= 1'b0;
    end else begin
      if (!enable) begin
        shadow_clk  <= clk_freq;
        shadow_baud <= baud_rate;
        cfg_err     <= cfg_bad_in;
      end
      if (resync || !enable || cfg_err) begin
        acc      <= '0;
        os_cnt   <= '0;
        os_tick  <= 1'b0;
        bit_tick <= 1'b0;
        mid_tick <= 1'b0;
      end else begin
        acc      <= acc_nxt;
        os_tick  <= wrap;
        bit_tick <= wrap && (os_cnt == OVS_LG'(OVS - 1));
        mid_tick <= wrap && (os_cnt == OVS_LG'(OVS / 2 - 1));
        if (wrap) os_cnt <= os_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Runtime-programmable fractional baud-rate generator for the UART TX/RX paths.
- A phase accumulator (Bresenham style) produces an oversample tick at exactly baud_rate*OVS ticks per clk_freq cycles on average, with no integer-division rounding error.
- Also derives a 1x bit tick and a mid-bit sample tick.
- A resync input realigns the phase to an RX start-bit edge.

Parameters:
- CLK_W, 32, width of clk_freq and of the accumulator.
- BAUD_W, 24, width of baud_rate.
- OVS, 16, oversampling factor; power of two, 4..256.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- clk_freq  in  CLK_W  system clock frequency in Hz.
- baud_rate  in  BAUD_W  target baud in bps.
- enable  in  1  run generator.
- resync  in  1  synchronous phase restart (RX start-bit detect).
- os_tick  out  1  one-cycle pulse at baud_rate*OVS rate.
- bit_tick  out  1  one-cycle pulse once per OVS os_ticks (bit boundary).
- mid_tick  out  1  one-cycle pulse at os count OVS/2 (mid-bit sample point).
- cfg_err  out  1  configuration invalid; no ticks generated.

Behaviour:
- Reset (async, rst_n=0): acc=0, os_cnt=0, shadow cfg=0. os_tick, bit_tick and mid_tick are 0. cfg_err=1, because the zeroed shadow is invalid.
- Config shadowing:
  - While enable=0, clk_freq and baud_rate are registered into shadow regs every cycle.
  - While enable=1 the shadow is frozen; input changes are ignored until the next enable=0 cycle.
- Increment: inc = shadow_baud * OVS, computed at CLK_W+1 bits with no truncation.
- cfg_err (registered from shadow) = (shadow_baud==0) | (shadow_clk==0) | (inc > shadow_clk).
- Accumulator:
  - Internal sum is CLK_W+1 bits wide; acc is always < shadow_clk.
  - Each cycle with enable=1, resync=0 and cfg_err=0: sum = acc + inc.
  - If sum >= shadow_clk: acc <= sum - shadow_clk and os_tick <= 1.
  - Otherwise: acc <= sum and os_tick <= 0.
- Outputs are registered; each tick is high for exactly one cycle.
- os_cnt counts os_ticks modulo OVS and wraps OVS-1 -> 0. On the edge that sets os_tick:
  - bit_tick <= 1 if os_cnt == OVS-1 before increment.
  - mid_tick <= 1 if os_cnt == OVS/2-1 before increment.
  - Otherwise both are 0.
- Priority (highest first): rst_n, resync, enable/cfg_err.
  - resync=1: acc<=0, os_cnt<=0, all ticks 0 that cycle. Works regardless of enable. The next accumulation starts on the following edge.
  - enable=0 or cfg_err=1: acc<=0, os_cnt<=0, all ticks 0.
- Latency: on the first enabled edge (edge 1) acc=0. os_tick is first high after edge ceil(shadow_clk/inc).
- After resync, the first mid_tick arrives after OVS/2 os_ticks and the first bit_tick after OVS os_ticks.
- Long-run accuracy: over N enabled cycles from acc=0, os_tick count = floor(N*inc/shadow_clk) exactly, and the os_tick gap varies by at most 1 cycle.
- Reset mid-operation: immediate return to reset values. After deassertion the generator needs one enable=0 cycle to load the shadow.
- Simultaneous resync and would-be tick: resync wins and no tick is emitted.

Test Plan:
- clk_freq=50_000_000, baud=115200, OVS=16:
  - Load the shadow with enable=0, then set enable=1.
  - First os_tick after edge 28.
  - os_tick gaps take only the values 27 and 28.
  - Over 1_000_000 enabled cycles: exactly 36864 os_ticks, 2304 bit_ticks, 2304 mid_ticks.
- clk_freq=1_843_200, baud=115200:
  - inc equals clk, so os_tick is high every cycle.
  - bit_tick every 16 cycles; mid_tick 8 cycles after each bit_tick.
- Error configs:
  - baud=0 -> cfg_err=1 and no ticks for 1000 cycles.
  - clk_freq=1_000_000, baud=115200 (inc=1_843_200 > clk) -> cfg_err=1.
  - Restore a valid config with enable=0 -> cfg_err=0.
- Resync:
  - Pulse resync for 1 cycle mid-bit.
  - All ticks stay 0 in that cycle; acc and os_cnt clear.
  - Next mid_tick arrives after 8 os_ticks and next bit_tick after 16 os_ticks, measured from resync.
  - A resync coinciding with an os_tick edge suppresses that tick.
- Config freeze:
  - Change baud to 9600 while enable=1 -> tick rate unchanged.
  - Drop enable for 1 cycle and re-enable -> new rate, first os_tick after edge ceil(50e6/153600)=326.
- Async reset asserted mid-stream:
  - Ticks drop to 0 immediately (without waiting for a clock edge).
  - After release, no ticks until the shadow is loaded and enable=1.
